// File: rtl/branch_resolver.sv
// Resolves fetch-time next-PC predictions: jumps in ID, conditional branches in EX.
// Drives BTB/BHT update strobes, redirect/flush controls and saturating statistics.
module branch_resolver #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic [WORD_SIZE-1:0] if_predicted_pc,
  input  logic                 id_is_jump,
  input  logic [WORD_SIZE-1:0] id_jump_target,
  input  logic                 id_is_branch,
  input  logic [WORD_SIZE-1:0] id_branch_target,
  input  logic                 ex_branch_taken,
  output logic                 update_tag,
  output logic [WORD_SIZE-1:0] pc_for_btb_update,
  output logic [WORD_SIZE-1:0] branch_target_for_btb_update,
  output logic                 update_bht,
  output logic [WORD_SIZE-1:0] pc_real,
  output logic                 branch_correct_or_notCorrect,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam logic [WORD_SIZE-1:0] WORD_ONE = WORD_SIZE'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic                 ifid_valid_reg;
  logic [WORD_SIZE-1:0] ifid_pc_reg;
  logic [WORD_SIZE-1:0] ifid_pred_reg;

  logic                 idex_valid_reg;
  logic                 idex_is_branch_reg;
  logic [WORD_SIZE-1:0] idex_pc_reg;
  logic [WORD_SIZE-1:0] idex_pred_reg;
  logic [WORD_SIZE-1:0] idex_target_reg;

  logic [CNT_WIDTH-1:0] branch_count_reg;
  logic [CNT_WIDTH-1:0] mispredict_count_reg;

  logic                 ex_resolve;
  logic                 ex_correct;
  logic                 ex_mispredict;
  logic [WORD_SIZE-1:0] ex_pc_real;
  logic                 id_live;
  logic                 id_jump;
  logic                 id_branch;
  logic                 jump_mispredict;

  always_comb begin
    ex_resolve      = idex_valid_reg & idex_is_branch_reg;
    ex_pc_real      = ex_branch_taken ? idex_target_reg : idex_pc_reg + WORD_ONE;
    ex_correct      = (idex_pred_reg == ex_pc_real);
    ex_mispredict   = ex_resolve & ~ex_correct;
    // An EX mispredict means the ID instruction is on the wrong path.
    id_live         = ifid_valid_reg & ~stall & ~ex_mispredict;
    id_jump         = id_live & id_is_jump;
    id_branch       = id_live & id_is_branch & ~id_is_jump;
    jump_mispredict = id_jump & (ifid_pred_reg != id_jump_target);
  end

  always_comb begin
    update_tag                   = id_jump | id_branch;
    pc_for_btb_update            = '0;
    branch_target_for_btb_update = '0;
    update_bht                   = ex_resolve | id_jump;
    pc_real                      = '0;
    branch_correct_or_notCorrect = 1'b0;
    redirect_valid               = ex_mispredict | jump_mispredict;
    redirect_pc                  = '0;
    flush_if                     = ex_mispredict | jump_mispredict;
    flush_id                     = ex_mispredict;

    if (update_tag) begin
      pc_for_btb_update            = ifid_pc_reg;
      branch_target_for_btb_update = id_jump ? id_jump_target : id_branch_target;
    end

    // EX owns the BHT port; a same-cycle ID jump loses only its BHT write.
    if (ex_resolve) begin
      pc_real                      = ex_pc_real;
      branch_correct_or_notCorrect = ex_correct;
    end else if (id_jump) begin
      pc_real                      = id_jump_target;
      branch_correct_or_notCorrect = ~jump_mispredict;
    end

    if (ex_mispredict) begin
      redirect_pc = ex_pc_real;
    end else if (jump_mispredict) begin
      redirect_pc = id_jump_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_reg       <= 1'b0;
      ifid_pc_reg          <= '0;
      ifid_pred_reg        <= '0;
      idex_valid_reg       <= 1'b0;
      idex_is_branch_reg   <= 1'b0;
      idex_pc_reg          <= '0;
      idex_pred_reg        <= '0;
      idex_target_reg      <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (flush_if) begin
        ifid_valid_reg <= 1'b0;
      end else if (!stall) begin
        ifid_valid_reg <= if_valid;
        ifid_pc_reg    <= if_pc;
        ifid_pred_reg  <= if_predicted_pc;
      end

      if (flush_id || stall) begin
        idex_valid_reg <= 1'b0;
      end else begin
        idex_valid_reg     <= ifid_valid_reg;
        idex_is_branch_reg <= id_is_branch;
        idex_pc_reg        <= ifid_pc_reg;
        idex_pred_reg      <= ifid_pred_reg;
        idex_target_reg    <= id_branch_target;
      end

      if (update_bht && branch_count_reg != CNT_MAX) begin
        branch_count_reg <= branch_count_reg + CNT_ONE;
      end
      if (update_bht && !branch_correct_or_notCorrect && mispredict_count_reg != CNT_MAX) begin
        mispredict_count_reg <= mispredict_count_reg + CNT_ONE;
      end
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: instruction-record pipeline model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolver;

  localparam int WS   = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [1:0] K_OTHER  = 2'd0;
  localparam logic [1:0] K_JUMP   = 2'd1;
  localparam logic [1:0] K_BRANCH = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [1:0]    kind;
    logic [WS-1:0] pc;
    logic [WS-1:0] pred;
    logic [WS-1:0] target;
    logic          taken;
  } instr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          if_valid;
  logic [WS-1:0] if_pc;
  logic [WS-1:0] if_predicted_pc;
  logic          id_is_jump;
  logic [WS-1:0] id_jump_target;
  logic          id_is_branch;
  logic [WS-1:0] id_branch_target;
  logic          ex_branch_taken;
  logic          update_tag;
  logic [WS-1:0] pc_for_btb_update;
  logic [WS-1:0] branch_target_for_btb_update;
  logic          update_bht;
  logic [WS-1:0] pc_real;
  logic          branch_correct_or_notCorrect;
  logic          redirect_valid;
  logic [WS-1:0] redirect_pc;
  logic          flush_if;
  logic          flush_id;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_resolver #(.WORD_SIZE(WS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_predicted_pc(if_predicted_pc),
    .id_is_jump(id_is_jump), .id_jump_target(id_jump_target),
    .id_is_branch(id_is_branch), .id_branch_target(id_branch_target),
    .ex_branch_taken(ex_branch_taken),
    .update_tag(update_tag), .pc_for_btb_update(pc_for_btb_update),
    .branch_target_for_btb_update(branch_target_for_btb_update),
    .update_bht(update_bht), .pc_real(pc_real),
    .branch_correct_or_notCorrect(branch_correct_or_notCorrect),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the instruction sitting in ID and in EX, plus counters.
  instr_t m_id, m_ex, cur_fetch;
  logic   cur_stall;
  int     m_bc, m_mc;

  // Expected outputs for the current cycle.
  logic          e_tag, e_bht, e_ok, e_redir, e_fif, e_fid;
  logic [WS-1:0] e_pcbtb, e_tgt, e_real, e_rpc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [1:0] k, input logic [WS-1:0] pc,
                                input logic [WS-1:0] pred, input logic [WS-1:0] tgt, input logic tk);
    instr_t r;
    r.valid = v; r.kind = k; r.pc = pc; r.pred = pred; r.target = tgt; r.taken = tk;
    return r;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, K_OTHER, 16'h0, 16'h0, 16'h0, 1'b0);
  endfunction

  task automatic compute_expect();
    logic          ex_res, ex_ok, ex_mis, live, jmp, brn, jmis;
    logic [WS-1:0] ex_next;
    ex_res  = m_ex.valid && m_ex.kind == K_BRANCH;
    ex_next = m_ex.taken ? m_ex.target : m_ex.pc + 16'd1;
    ex_ok   = (m_ex.pred == ex_next);
    ex_mis  = ex_res && !ex_ok;
    live    = m_id.valid && !cur_stall && !ex_mis;
    jmp     = live && m_id.kind == K_JUMP;
    brn     = live && m_id.kind == K_BRANCH;
    jmis    = jmp && (m_id.pred != m_id.target);
    e_tag   = jmp || brn;
    e_pcbtb = e_tag ? m_id.pc : 16'h0;
    e_tgt   = e_tag ? m_id.target : 16'h0;
    e_bht   = ex_res || jmp;
    e_real  = ex_res ? ex_next : (jmp ? m_id.target : 16'h0);
    e_ok    = ex_res ? ex_ok : (jmp ? !jmis : 1'b0);
    e_redir = ex_mis || jmis;
    e_rpc   = ex_mis ? ex_next : (jmis ? m_id.target : 16'h0);
    e_fif   = e_redir;
    e_fid   = ex_mis;
  endtask

  // Drive one cycle's inputs at the falling edge, then compare every output.
  task automatic drive_and_check(input instr_t f, input logic st);
    @(negedge clk);
    cur_fetch = f;
    cur_stall = st;
    stall           = st;
    if_valid        = f.valid;
    if_pc           = f.pc;
    if_predicted_pc = f.pred;
    if (m_id.valid) begin
      id_is_jump       = (m_id.kind == K_JUMP);
      id_is_branch     = (m_id.kind == K_BRANCH);
      id_jump_target   = (m_id.kind == K_JUMP)   ? m_id.target : WS'($urandom);
      id_branch_target = (m_id.kind == K_BRANCH) ? m_id.target : WS'($urandom);
    end else begin
      id_is_jump       = 1'($urandom);
      id_is_branch     = 1'($urandom);
      id_jump_target   = WS'($urandom);
      id_branch_target = WS'($urandom);
    end
    ex_branch_taken = (m_ex.valid && m_ex.kind == K_BRANCH) ? m_ex.taken : 1'($urandom);
    compute_expect();
    #1;
    chk("update_tag",     int'(update_tag), int'(e_tag));
    chk("pc_for_btb",     int'(pc_for_btb_update), int'(e_pcbtb));
    chk("btb_target",     int'(branch_target_for_btb_update), int'(e_tgt));
    chk("update_bht",     int'(update_bht), int'(e_bht));
    chk("pc_real",        int'(pc_real), int'(e_real));
    chk("correct",        int'(branch_correct_or_notCorrect), int'(e_ok));
    chk("redirect_valid", int'(redirect_valid), int'(e_redir));
    chk("redirect_pc",    int'(redirect_pc), int'(e_rpc));
    chk("flush_if",       int'(flush_if), int'(e_fif));
    chk("flush_id",       int'(flush_id), int'(e_fid));
    chk("branch_count",   int'(branch_count), m_bc);
    chk("mispred_count",  int'(mispredict_count), m_mc);
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_bht && m_bc < CMAX) m_bc++;
    if (e_bht && !e_ok && m_mc < CMAX) m_mc++;
    if (e_fid || cur_stall) m_ex = nop(); else m_ex = m_id;
    if (e_fif) m_id = nop(); else if (!cur_stall) m_id = cur_fetch;
  endtask

  task automatic step(input instr_t f, input logic st);
    drive_and_check(f, st);
    advance();
  endtask

  function automatic instr_t rand_fetch();
    instr_t r;
    int     sel;
    r.valid  = ($urandom_range(0, 99) < 85);
    sel      = $urandom_range(0, 3);
    r.kind   = (sel == 0) ? K_OTHER : (sel == 1) ? K_JUMP : K_BRANCH;
    r.pc     = WS'($urandom);
    r.target = ($urandom_range(0, 9) == 0) ? 16'hFFFF : WS'($urandom);
    r.taken  = 1'($urandom);
    sel      = $urandom_range(0, 3);
    r.pred   = (sel == 0) ? r.pc + 16'd1 : (sel == 3) ? WS'($urandom) : r.target;
    if (r.valid && $urandom_range(0, 19) == 0) r.pc = 16'hFFFF;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    m_id = nop(); m_ex = nop(); m_bc = 0; m_mc = 0;
    #1;
    chk("rst_update_tag", int'(update_tag), 0);
    chk("rst_update_bht", int'(update_bht), 0);
    chk("rst_redirect",   int'(redirect_valid), 0);
    chk("rst_flush_if",   int'(flush_if), 0);
    chk("rst_flush_id",   int'(flush_id), 0);
    chk("rst_pc_real",    int'(pc_real), 0);
    chk("rst_branch_cnt", int'(branch_count), 0);
    chk("rst_mispr_cnt",  int'(mispredict_count), 0);
    @(negedge clk);
    if_valid = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; if_valid = 1'b1; if_pc = 16'h1234; if_predicted_pc = 16'h9999;
    id_is_jump = 1'b1; id_jump_target = 16'h4444; id_is_branch = 1'b0;
    id_branch_target = 16'h0; ex_branch_taken = 1'b1;
    m_id = nop(); m_ex = nop(); cur_fetch = nop(); cur_stall = 1'b0; m_bc = 0; m_mc = 0;
    #2;
    do_reset();

    // Jump predicted correctly.
    step(mk(1'b1, K_JUMP, 16'h0010, 16'h0040, 16'h0040, 1'b0), 1'b0);
    drive_and_check(nop(), 1'b0);
    chk("jc_tag", int'(update_tag), 1);
    chk("jc_bht", int'(update_bht), 1);
    chk("jc_ok",  int'(branch_correct_or_notCorrect), 1);
    chk("jc_redirect", int'(redirect_valid), 0);
    advance();

    // Jump mispredicted: one-bubble redirect, IF/ID only.
    step(mk(1'b1, K_JUMP, 16'h0010, 16'h0011, 16'h0040, 1'b0), 1'b0);
    drive_and_check(nop(), 1'b0);
    chk("jm_redirect_pc", int'(redirect_pc), 16'h0040);
    chk("jm_flush_if", int'(flush_if), 1);
    chk("jm_flush_id", int'(flush_id), 0);
    advance();
    drive_and_check(nop(), 1'b0);
    chk("jm_mispred_cnt", int'(mispredict_count), 1);
    chk("jm_branch_cnt", int'(branch_count), 2);
    advance();

    // Branch predicted taken, actually not taken.
    step(mk(1'b1, K_BRANCH, 16'h0020, 16'h0030, 16'h0030, 1'b0), 1'b0);
    drive_and_check(nop(), 1'b0);
    chk("bn_id_tag", int'(update_tag), 1);
    chk("bn_id_bht", int'(update_bht), 0);
    advance();
    drive_and_check(nop(), 1'b0);
    chk("bn_pc_real", int'(pc_real), 16'h0021);
    chk("bn_ok", int'(branch_correct_or_notCorrect), 0);
    chk("bn_flush_if", int'(flush_if), 1);
    chk("bn_flush_id", int'(flush_id), 1);
    chk("bn_redirect_pc", int'(redirect_pc), 16'h0021);
    advance();
    step(nop(), 1'b0);

    // Jump held in ID by stall: exactly one tag pulse, on release.
    step(mk(1'b1, K_JUMP, 16'h0050, 16'h0060, 16'h0060, 1'b0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_and_check(nop(), 1'b1);
      chk("st_hold_tag", int'(update_tag), 0);
      advance();
    end
    drive_and_check(nop(), 1'b0);
    chk("st_release_tag", int'(update_tag), 1);
    chk("st_release_pc", int'(pc_for_btb_update), 16'h0050);
    advance();
    drive_and_check(nop(), 1'b0);
    chk("st_after_tag", int'(update_tag), 0);
    advance();

    // EX mispredict collides with an ID jump: only EX strobes.
    step(mk(1'b1, K_BRANCH, 16'h0070, 16'h0071, 16'h0090, 1'b1), 1'b0);
    step(mk(1'b1, K_JUMP, 16'h0071, 16'h0072, 16'h0080, 1'b0), 1'b0);
    drive_and_check(nop(), 1'b0);
    chk("col_tag", int'(update_tag), 0);
    chk("col_bht", int'(update_bht), 1);
    chk("col_pc_real", int'(pc_real), 16'h0090);
    chk("col_redirect_pc", int'(redirect_pc), 16'h0090);
    chk("col_flush_id", int'(flush_id), 1);
    advance();
    step(nop(), 1'b0);

    // Randomized traffic with a mid-flight reset.
    for (int n = 0; n < 3000; n++) begin
      step(rand_fetch(), ($urandom_range(0, 99) < 20));
      if (n == 1500) begin
        @(negedge clk);
        if_valid = 1'b1; id_is_jump = 1'b1; id_is_branch = 1'b1;
        #2;
        do_reset();
      end
    end

    // Saturation: mispredicting jumps until both counters pin at all-ones.
    for (int n = 0; n < CMAX + 8; n++) begin
      step(mk(1'b1, K_JUMP, 16'h0100, 16'h0101, 16'h0200, 1'b0), 1'b0);
      step(nop(), 1'b0);
    end
    drive_and_check(nop(), 1'b0);
    chk("sat_branch_cnt", int'(branch_count), CMAX);
    chk("sat_mispr_cnt", int'(mispredict_count), CMAX);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
